// File: rtl/keypad_event_fifo_if.sv
// Key-event interface between the keypad qualifier/FIFO and its consumer.
// The signal names follow the scanner-side pin names.
interface keypad_event_fifo_if;
  logic [3:0] keyCode;
  logic       popKey;
  logic       clearOverflow;
  logic [3:0] keyOut_reg;
  logic       keyValid_reg;
  logic       fifoFull_reg;
  logic       overflow_reg;
  logic [3:0] heldKey_reg;

  modport master (
    output keyCode, popKey, clearOverflow,
    input  keyOut_reg, keyValid_reg, fifoFull_reg, overflow_reg, heldKey_reg
  );

  modport slave (
    input  keyCode, popKey, clearOverflow,
    output keyOut_reg, keyValid_reg, fifoFull_reg, overflow_reg, heldKey_reg
  );
endinterface

// File: rtl/keypad_event_fifo.sv
// Keypad code qualifier: debounces the scanner code and pushes each new
// qualified press once into a small circular FIFO read by the consumer.
module keypad_event_fifo #(
  parameter int STABLE_CYCLES = 4,
  parameter int DEPTH_LOG2    = 3
) (
  input logic                scanClock,
  input logic                nReset,
  keypad_event_fifo_if.slave bus
);
  localparam int AW = DEPTH_LOG2;
  localparam int PW = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, QUAL, HELD} state_t;

  state_t     state, state_nxt;
  logic [3:0] candidate, cand_nxt;
  logic [3:0] held, held_nxt;
  logic [7:0] count, count_nxt;
  logic       chk_acc;
  logic       push;

  // Qualifier next-state; the push must land on the same edge as acceptance,
  // so acceptance is resolved here rather than one cycle later.
  always_comb begin
    state_nxt = state;
    cand_nxt  = candidate;
    count_nxt = count;
    held_nxt  = held;
    chk_acc   = 1'b0;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.keyCode != 4'd0) begin
          cand_nxt  = bus.keyCode;
          count_nxt = 8'd1;
          state_nxt = QUAL;
          chk_acc   = 1'b1;
        end
      end
      QUAL: begin
        if (bus.keyCode == candidate) begin
          count_nxt = count + 8'd1;
        end else begin
          cand_nxt  = bus.keyCode;
          count_nxt = 8'd1;
        end
        chk_acc = 1'b1;
      end
      HELD: begin
        if (bus.keyCode != held) begin
          cand_nxt  = bus.keyCode;
          count_nxt = 8'd1;
          state_nxt = QUAL;
          chk_acc   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (chk_acc && (count_nxt >= 8'(STABLE_CYCLES))) begin
      if (cand_nxt == 4'd0) begin
        held_nxt  = 4'd0;
        state_nxt = IDLE;
      end else if (cand_nxt == held) begin
        state_nxt = HELD;
      end else begin
        held_nxt  = cand_nxt;
        state_nxt = HELD;
        push      = 1'b1;
      end
    end
  end

  always_ff @(posedge scanClock or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      candidate <= 4'd0;
      count     <= 8'd0;
      held      <= 4'd0;
    end else begin
      state     <= state_nxt;
      candidate <= cand_nxt;
      count     <= count_nxt;
      held      <= held_nxt;
    end
  end

  logic [PW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [3:0]    mem [DEPTH];
  logic          empty, full, do_pop, do_push, drop;
  logic [3:0]    head_nxt;
  logic [3:0]    head;
  logic          valid_q, full_q, ovf_q;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = bus.popKey && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign rd_nxt  = rd_ptr + PW'(do_pop);
  assign wr_nxt  = wr_ptr + PW'(do_push);

  // The new head may be the entry being written this very edge.
  assign head_nxt = (do_push && (wr_ptr[AW-1:0] == rd_nxt[AW-1:0])) ?
                    cand_nxt : mem[rd_nxt[AW-1:0]];

  always_ff @(posedge scanClock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= cand_nxt;
  end

  always_ff @(posedge scanClock or negedge nReset) begin
    if (!nReset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      head    <= 4'd0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wr_ptr  <= wr_nxt;
      rd_ptr  <= rd_nxt;
      head    <= head_nxt;
      valid_q <= (wr_nxt != rd_nxt);
      full_q  <= (wr_nxt[PW-1] != rd_nxt[PW-1]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
      if (drop)                   ovf_q <= 1'b1;
      else if (bus.clearOverflow) ovf_q <= 1'b0;
    end
  end

  assign bus.keyOut_reg   = head;
  assign bus.keyValid_reg = valid_q;
  assign bus.fifoFull_reg = full_q;
  assign bus.overflow_reg = ovf_q;
  assign bus.heldKey_reg  = held;
endmodule

// File: tb/tb_keypad_event_fifo.sv
// Randomized bench for keypad_event_fifo against a run-length/queue model.
module tb_keypad_event_fifo;
  localparam int N     = 4;
  localparam int DEPTH = 8;

  logic scanClock = 1'b0;
  logic nReset;
  keypad_event_fifo_if bus();

  keypad_event_fifo #(.STABLE_CYCLES(N), .DEPTH_LOG2(3)) dut (
    .scanClock(scanClock),
    .nReset   (nReset),
    .bus      (bus)
  );

  always #5 scanClock = ~scanClock;

  int n_chk = 0;
  int n_err = 0;

  // Model: a press qualifies when the current run of identical samples
  // reaches exactly N; events queue in order, capped at DEPTH.
  int         run_len;
  logic [3:0] run_code;
  logic [3:0] m_held;
  bit         m_ovf;
  logic [3:0] q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    run_len  = 0;
    run_code = 4'd0;
    m_held   = 4'd0;
    m_ovf    = 1'b0;
    q.delete();
  endtask

  task automatic model_edge(input logic [3:0] c, input logic p, input logic cl);
    bit psh;
    bit drp;
    psh = 1'b0;
    drp = 1'b0;
    if (run_len > 0 && c == run_code) run_len++;
    else begin
      run_code = c;
      run_len  = 1;
    end
    if (run_len == N) begin
      if (run_code == 4'd0) m_held = 4'd0;
      else if (run_code != m_held) begin
        m_held = run_code;
        psh    = 1'b1;
      end
    end
    if (p && q.size() > 0) void'(q.pop_front());
    if (psh) begin
      if (q.size() < DEPTH) q.push_back(c);
      else drp = 1'b1;
    end
    if (drp) m_ovf = 1'b1;
    else if (cl) m_ovf = 1'b0;
  endtask

  task automatic compare_all();
    chk("valid", bus.keyValid_reg, q.size() != 0);
    chk("full",  bus.fifoFull_reg, q.size() == DEPTH);
    chk("ovf",   bus.overflow_reg, m_ovf);
    chk("held",  bus.heldKey_reg,  m_held);
    if (q.size() != 0) chk("head", bus.keyOut_reg, q[0]);
  endtask

  task automatic step(input logic [3:0] c, input logic p, input logic cl);
    bus.keyCode       = c;
    bus.popKey        = p;
    bus.clearOverflow = cl;
    @(posedge scanClock);
    model_edge(c, p, cl);
    #1;
    compare_all();
  endtask

  task automatic hold(input logic [3:0] c, input int n);
    for (int i = 0; i < n; i++) step(c, 1'b0, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_out"},   bus.keyOut_reg,   0);
    chk({tag, "_valid"}, bus.keyValid_reg, 0);
    chk({tag, "_full"},  bus.fifoFull_reg, 0);
    chk({tag, "_ovf"},   bus.overflow_reg, 0);
    chk({tag, "_held"},  bus.heldKey_reg,  0);
  endtask

  task automatic async_reset();
    #2 nReset = 1'b0;
    #1 check_zero("rst_async");
    model_reset();
    repeat (2) @(posedge scanClock);
    @(negedge scanClock) nReset = 1'b1;
  endtask

  initial begin
    logic [3:0] c;
    int         len;

    nReset = 1'b0;
    bus.keyCode = 4'd0;
    bus.popKey = 1'b0;
    bus.clearOverflow = 1'b0;
    model_reset();
    #1 check_zero("rst_init");
    repeat (3) @(posedge scanClock);
    @(negedge scanClock) nReset = 1'b1;

    // Single press, latency N, no repeat while held
    hold(4'd0, 2);
    hold(4'd5, N - 1);
    chk("press_early", bus.keyValid_reg, 0);
    step(4'd5, 1'b0, 1'b0);
    chk("press_valid", bus.keyValid_reg, 1);
    chk("press_head",  bus.keyOut_reg,   5);
    hold(4'd5, 100);
    step(4'd5, 1'b1, 1'b0);
    chk("press_once", bus.keyValid_reg, 0);

    // Glitches
    hold(4'd0, N);
    hold(4'd5, N - 1);
    hold(4'd0, N);
    chk("glitch_short", bus.keyValid_reg, 0);
    hold(4'd5, N);
    step(4'd5, 1'b1, 1'b0);
    hold(4'd7, 2);
    hold(4'd5, 6);
    chk("glitch_held", bus.heldKey_reg, 5);
    chk("glitch_nopush", bus.keyValid_reg, 0);

    // Repeat via release, then direct switch
    hold(4'd0, N); hold(4'd5, N); hold(4'd0, N); hold(4'd5, N);
    step(4'd5, 1'b1, 1'b0);
    chk("repeat_second", bus.keyValid_reg, 1);
    step(4'd5, 1'b1, 1'b0);
    chk("repeat_two", bus.keyValid_reg, 0);
    hold(4'd9, N);
    chk("switch_head", bus.keyOut_reg, 9);
    step(4'd9, 1'b1, 1'b0);

    // Overflow
    for (int k = 1; k <= 9; k++) begin
      hold(4'(k), N);
      if (k == 8) chk("full8", bus.fifoFull_reg, 1);
    end
    chk("ovf9", bus.overflow_reg, 1);
    for (int k = 1; k <= 8; k++) begin
      chk("ovf_order", bus.keyOut_reg, k);
      step(4'd9, 1'b1, 1'b0);
    end
    chk("ovf_drained", bus.keyValid_reg, 0);
    step(4'd9, 1'b0, 1'b1);
    chk("ovf_clear", bus.overflow_reg, 0);

    // Push+pop on the same edge: full, then empty
    hold(4'd0, N);
    for (int k = 1; k <= 8; k++) hold(4'(k), N);
    hold(4'd3, N - 1);
    step(4'd3, 1'b1, 1'b0);
    chk("pp_full", bus.fifoFull_reg, 1);
    chk("pp_full_ovf", bus.overflow_reg, 0);
    repeat (8) step(4'd3, 1'b1, 1'b0);
    hold(4'd0, N);
    hold(4'd6, N - 1);
    step(4'd6, 1'b1, 1'b0);
    chk("pp_empty_valid", bus.keyValid_reg, 1);
    chk("pp_empty_head",  bus.keyOut_reg,   6);

    // Mid-operation reset
    async_reset();
    compare_all();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       c = 4'd0;
        1:       c = 4'd5;
        2:       c = 4'd9;
        default: c = 4'($urandom_range(0, 15));
      endcase
      len = $urandom_range(1, 7);
      for (int j = 0; j < len; j++)
        step(c, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 99) == 0) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
